// File: rtl/cic_pkg.sv
// Shared CIC helpers: bit-growth, phase width and mode strings.
// Used by both the interpolator and the decimator.
package cic_pkg;

  localparam string MODE_TRUE  = "TRUE";
  localparam string MODE_FALSE = "FALSE";

  // Output bits added by the comb/integrator gain R^(M-1)
  function automatic int cic_growth(input int m, input int r);
    return (m - 1) * $clog2(r);
  endfunction

  function automatic int ph_width(input int r);
    return $clog2(r);
  endfunction

endpackage

// File: rtl/cic_comb_section.sv
// Low-rate comb cascade for the CIC interpolator.
// Delay registers advance only on an accepted input beat.
module cic_comb_section
  import cic_pkg::*;
#(
  parameter int M  = 3,
  parameter int IW = 8,
  parameter int OW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] c_m
);

  logic signed [OW-1:0] d [M];
  logic signed [OW-1:0] c [M];

  always_comb begin
    logic signed [OW-1:0] acc;
    acc = OW'($signed(din));
    for (int k = 0; k < M; k++) begin
      c[k] = acc;
      acc  = acc - d[k];
    end
    c_m = acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < M; k++) d[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < M; k++) d[k] <= c[k];
    end
  end

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator: low-rate combs, zero-stuffing upsampler,
// high-rate integrators, AXI-Stream in and out.
module cic_interp
  import cic_pkg::*;
#(
  parameter int    M        = 3,
  parameter int    R        = 2,
  parameter int    IW       = 8,
  parameter int    OW       = IW + cic_growth(M, R),
  parameter string TRUNCATE = MODE_FALSE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [IW-1:0] axis_i_tdata,
  input  logic                 axis_i_tvalid,
  output logic                 axis_i_tready,
  output logic signed [OW-1:0] axis_o_tdata,
  output logic                 axis_o_tvalid,
  input  logic                 axis_o_tready
);

  localparam int PW   = ph_width(R);
  localparam int SH   = cic_growth(M, R);
  localparam bit TRUNC = (TRUNCATE == MODE_TRUE);
  localparam logic [PW-1:0] PH_LAST = PW'(R - 1);

  logic                 hold_valid;
  logic signed [OW-1:0] hold_data;
  logic signed [OW-1:0] c_m;
  logic [PW-1:0]        ph;
  logic signed [OW-1:0] integ [M];
  logic signed [OW-1:0] s [M];
  logic signed [OW-1:0] x;
  logic signed [OW-1:0] y;
  logic                 step;
  logic                 last;
  logic                 accept;

  assign last          = (ph == PH_LAST);
  assign step          = hold_valid & (~axis_o_tvalid | axis_o_tready);
  assign axis_i_tready = ~hold_valid | (step & last);
  assign accept        = axis_i_tvalid & axis_i_tready;

  cic_comb_section #(
    .M (M),
    .IW(IW),
    .OW(OW)
  ) u_comb (
    .clk(clk),
    .rst(rst),
    .en (accept),
    .din(axis_i_tdata),
    .c_m(c_m)
  );

  // Zero-stuff then run the integrators as one combinational cascade
  always_comb begin
    logic signed [OW-1:0] acc;
    x   = (ph == '0) ? hold_data : '0;
    acc = x;
    for (int k = 0; k < M; k++) begin
      acc  = integ[k] + acc;
      s[k] = acc;
    end
    y = TRUNC ? (acc >>> SH) : acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid    <= 1'b0;
      hold_data     <= '0;
      ph            <= '0;
      axis_o_tvalid <= 1'b0;
      axis_o_tdata  <= '0;
      for (int k = 0; k < M; k++) integ[k] <= '0;
    end else begin
      if (accept) begin
        hold_data  <= c_m;
        hold_valid <= 1'b1;
      end else if (step && last) begin
        hold_valid <= 1'b0;
      end
      if (step) begin
        for (int k = 0; k < M; k++) integ[k] <= s[k];
        axis_o_tdata  <= y;
        axis_o_tvalid <= 1'b1;
        ph            <= ph + 1'b1;
      end else if (axis_o_tready) begin
        axis_o_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_interp.sv
// Directed bench for cic_interp: impulse, DC, full scale,
// backpressure, R=4 streaming and mid-burst reset.
module tb_cic_interp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [7:0]  i_data;
  logic               i_valid;
  logic               o_ready;

  logic               i0_ready, o0_valid;
  logic signed [9:0]  o0_data;
  logic               it_ready, ot_valid;
  logic signed [9:0]  ot_data;
  logic               i4_ready, o4_valid;
  logic signed [11:0] o4_data;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] src [64];
  int  src_n  = 0;
  int  idx    = 0;
  bit  src_en = 1'b0;
  bit  fire   = 1'b0;

  logic signed [9:0]  q0 [$];
  logic signed [9:0]  qt [$];
  logic signed [11:0] q4 [$];

  assign i_valid = src_en && (idx < src_n);
  assign i_data  = (idx < src_n) ? src[idx] : 8'sd0;

  cic_interp dut (
    .clk(clk), .rst(rst),
    .axis_i_tdata(i_data), .axis_i_tvalid(i_valid),
    .axis_i_tready(i0_ready),
    .axis_o_tdata(o0_data), .axis_o_tvalid(o0_valid),
    .axis_o_tready(o_ready)
  );

  cic_interp #(.TRUNCATE("TRUE")) dut_t (
    .clk(clk), .rst(rst),
    .axis_i_tdata(i_data), .axis_i_tvalid(i_valid),
    .axis_i_tready(it_ready),
    .axis_o_tdata(ot_data), .axis_o_tvalid(ot_valid),
    .axis_o_tready(o_ready)
  );

  cic_interp #(.R(4)) dut4 (
    .clk(clk), .rst(rst),
    .axis_i_tdata(i_data), .axis_i_tvalid(i_valid),
    .axis_i_tready(i4_ready),
    .axis_o_tdata(o4_data), .axis_o_tvalid(o4_valid),
    .axis_o_tready(o_ready)
  );

  // Source advances on handshakes of the R=2 reference instance
  initial forever begin
    @(negedge clk);
    fire = i_valid && i0_ready && !rst;
    @(posedge clk);
    #1;
    if (fire) idx++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (o0_valid && o_ready) q0.push_back(o0_data);
      if (ot_valid && o_ready) qt.push_back(ot_data);
      if (o4_valid && o_ready) q4.push_back(o4_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    tick(1);
    rst = 1'b1;
    src_en = 1'b0;
    o_ready = 1'b1;
    tick(2);
    idx = 0;
    src_n = 0;
    q0.delete();
    qt.delete();
    q4.delete();
    rst = 1'b0;
  endtask

  task automatic load_const(input int n, input int v);
    for (int i = 0; i < n; i++) src[i] = 8'(v);
    src_n = n;
    idx = 0;
    src_en = 1'b1;
  endtask

  task automatic load_impulse;
    src[0] = 8'sd1;
    for (int i = 1; i < 4; i++) src[i] = 8'sd0;
    src_n = 4;
    idx = 0;
    src_en = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (o0_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_tvalid got %b want 0", o0_valid);
    end
    checks++;
    if (o0_data !== 10'sd0) begin
      errors++;
      $display("FAIL reset_tdata got %0d want 0", o0_data);
    end
    checks++;
    if (i0_ready !== 1'b1 || it_ready !== 1'b1 || i4_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready got %b%b%b want 111",
               i0_ready, it_ready, i4_ready);
    end
  endtask

  task automatic test_impulse(input string tag);
    int exp_v [8] = '{1, 3, 3, 1, 0, 0, 0, 0};
    int first = -1;
    load_impulse();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (o0_valid && first < 0) first = k;
    end
    checks++;
    if (first != 2) begin
      errors++;
      $display("FAIL %s_latency got %0d want 2", tag, first);
    end
    checks++;
    if (q0.size() != 8) begin
      errors++;
      $display("FAIL %s_count got %0d want 8", tag, q0.size());
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= q0.size() || int'(q0[k]) != exp_v[k]) begin
        errors++;
        $display("FAIL %s_out%0d got %0d want %0d", tag, k,
                 (k < q0.size()) ? int'(q0[k]) : -9999, exp_v[k]);
      end
    end
  endtask

  task automatic run_dc(input int v, input int e0, input int e1,
                        input int e2, input string tag);
    int want;
    do_reset();
    load_const(8, v);
    tick(24);
    checks++;
    if (q0.size() != 16) begin
      errors++;
      $display("FAIL %s_count got %0d want 16", tag, q0.size());
    end
    for (int k = 0; k < 16; k++) begin
      want = (k == 0) ? e0 : (k == 1) ? e1 : e2;
      checks++;
      if (k >= q0.size() || int'(q0[k]) != want) begin
        errors++;
        $display("FAIL %s_out%0d got %0d want %0d", tag, k,
                 (k < q0.size()) ? int'(q0[k]) : -9999, want);
      end
    end
  endtask

  task automatic test_dc;
    int want;
    run_dc(1, 1, 3, 4, "dc");
    checks++;
    if (qt.size() != 16) begin
      errors++;
      $display("FAIL dc_trunc_count got %0d want 16", qt.size());
    end
    for (int k = 0; k < 16; k++) begin
      want = (k < 2) ? 0 : 1;
      checks++;
      if (k >= qt.size() || int'(qt[k]) != want) begin
        errors++;
        $display("FAIL dc_trunc_out%0d got %0d want %0d", k,
                 (k < qt.size()) ? int'(qt[k]) : -9999, want);
      end
    end
  endtask

  task automatic test_full_scale;
    run_dc(-128, -128, -384, -512, "fs_neg");
    run_dc(127, 127, 381, 508, "fs_pos");
  endtask

  task automatic test_backpressure;
    int n;
    do_reset();
    load_impulse();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o0_valid && n < 40);
    checks++;
    if (!o0_valid) begin
      errors++;
      $display("FAIL bp_first_valid got 0 want 1 (timeout)");
    end
    tick(1);
    o_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (o0_valid !== 1'b1 || o0_data !== 10'sd3) begin
        errors++;
        $display("FAIL bp_stall%0d got v=%b d=%0d want v=1 d=3",
                 k, o0_valid, o0_data);
      end
      checks++;
      if (i0_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_tready%0d got %b want 0", k, i0_ready);
      end
    end
    tick(1);
    o_ready = 1'b1;
    tick(20);
    begin
      int exp_v [8] = '{1, 3, 3, 1, 0, 0, 0, 0};
      checks++;
      if (q0.size() != 8) begin
        errors++;
        $display("FAIL bp_count got %0d want 8", q0.size());
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (k >= q0.size() || int'(q0[k]) != exp_v[k]) begin
          errors++;
          $display("FAIL bp_out%0d got %0d want %0d", k,
                   (k < q0.size()) ? int'(q0[k]) : -9999, exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_streaming;
    do_reset();
    load_const(40, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (i4_ready !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL r4_tready%0d got %b want %b", k, i4_ready,
                 ((k % 4) == 0));
      end
      checks++;
      if (o4_valid !== (k >= 2)) begin
        errors++;
        $display("FAIL r4_tvalid%0d got %b want %b", k, o4_valid,
                 (k >= 2));
      end
    end
    tick(1);
    checks++;
    if (q4.size() < 12 || int'(q4[q4.size()-1]) != 16) begin
      errors++;
      $display("FAIL r4_dc got %0d (n=%0d) want 16",
               (q4.size() > 0) ? int'(q4[q4.size()-1]) : -9999,
               q4.size());
    end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset();
    load_impulse();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o0_valid && n < 40);
    checks++;
    if (!o0_valid) begin
      errors++;
      $display("FAIL rm_first_valid got 0 want 1 (timeout)");
    end
    tick(1);
    rst = 1'b1;
    src_en = 1'b0;
    @(negedge clk);
    checks++;
    if (o0_valid !== 1'b0 || o0_data !== 10'sd0 || i0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_cleared got v=%b d=%0d r=%b want v=0 d=0 r=1",
               o0_valid, o0_data, i0_ready);
    end
    tick(2);
    idx = 0;
    src_n = 0;
    q0.delete();
    qt.delete();
    q4.delete();
    rst = 1'b0;
    tick(6);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL rm_residual got %0d want 0", q0.size());
    end
    tick(1);
    test_impulse("rm_imp");
  endtask

  initial begin
    o_ready = 1'b1;
    test_reset();
    do_reset();
    test_impulse("imp");
    test_dc();
    test_full_scale();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
